// File: rtl/p4_mem_wb_if.sv
// Bundle between p3 outputs, the data memory and the register-file write port.
// master drives pipeline inputs and memory responses; slave is the p4 stage.
interface p4_mem_wb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int REG_AW = 3
);
   logic [DATA_W-1:0] aluOutput;
   logic              writeRegp3;
   logic [REG_AW-1:0] regAddressp3;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] storeData;
   logic              readEnable;
   logic              writeEnable;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              stall;
   logic              mem_err;

   modport master (
      output aluOutput, writeRegp3, regAddressp3, Address, storeData,
             readEnable, writeEnable, mem_rdata, mem_ready,
      input  mem_addr, mem_wdata, mem_re, mem_we, wb_en, wb_addr, wb_data,
             stall, mem_err
   );

   modport slave (
      input  aluOutput, writeRegp3, regAddressp3, Address, storeData,
             readEnable, writeEnable, mem_rdata, mem_ready,
      output mem_addr, mem_wdata, mem_re, mem_we, wb_en, wb_addr, wb_data,
             stall, mem_err
   );
endinterface

// File: rtl/p4_mem_wb.sv
// MEM/WB stage: ALU writeback in 1 cycle; loads/stores wait on mem_ready (bounded by TIMEOUT)
// while stall holds p3; writeback of a load lands the cycle after mem_ready.
module p4_mem_wb #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int REG_AW  = 3,
   parameter int TIMEOUT = 15
) (
   input logic         clk,
   input logic         rst_n,
   p4_mem_wb_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_re;
   logic              r_mem_we;
   logic              r_wb_en;
   logic [REG_AW-1:0] r_wb_addr;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_mem_err;
   logic              r_ld_wr;
   logic              w_tmo;

   // The wait cycle in which the counter would reach TIMEOUT is the last one granted.
   assign w_tmo = (r_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_wb_en     <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_mem_err   <= 1'b0;
         r_ld_wr     <= 1'b0;
      end else begin
         r_wb_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.readEnable && bus.writeEnable) begin
                  r_mem_err <= 1'b1;
               end else if (bus.readEnable) begin
                  r_mem_addr <= bus.Address;
                  r_wb_addr  <= bus.regAddressp3;
                  r_ld_wr    <= bus.writeRegp3;
                  r_mem_re   <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= RD_WAIT;
               end else if (bus.writeEnable) begin
                  r_mem_addr  <= bus.Address;
                  r_mem_wdata <= bus.storeData;
                  r_mem_we    <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= WR_WAIT;
               end else begin
                  r_wb_en   <= bus.writeRegp3;
                  r_wb_addr <= bus.regAddressp3;
                  r_wb_data <= bus.aluOutput;
               end
            end
            RD_WAIT: begin
               if (bus.mem_ready) begin
                  r_mem_re  <= 1'b0;
                  r_wb_en   <= r_ld_wr;
                  r_wb_data <= bus.mem_rdata;
                  r_state   <= IDLE;
               end else if (w_tmo) begin
                  r_mem_re  <= 1'b0;
                  r_mem_err <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            WR_WAIT: begin
               if (bus.mem_ready) begin
                  r_mem_we <= 1'b0;
                  r_state  <= IDLE;
               end else if (w_tmo) begin
                  r_mem_we  <= 1'b0;
                  r_mem_err <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_re    = r_mem_re;
   assign bus.mem_we    = r_mem_we;
   assign bus.wb_en     = r_wb_en;
   assign bus.wb_addr   = r_wb_addr;
   assign bus.wb_data   = r_wb_data;
   assign bus.mem_err   = r_mem_err;
   assign bus.stall     = (r_state != IDLE);
endmodule
